// File: rtl/rvc_pkg.sv
// Shared RISC-V encodings for the compressed-instruction expander and fetch aligner:
// base opcodes, funct codes, RVC quadrant/funct3 codes and 32-bit encoders.
package rvc_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_FLD      = 3'b001;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_FLW_LD   = 3'b011;
    localparam logic [2:0] C0_FSD      = 3'b101;
    localparam logic [2:0] C0_SW       = 3'b110;
    localparam logic [2:0] C0_FSW_SD   = 3'b111;

    localparam logic [2:0] C1_ADDI       = 3'b000;
    localparam logic [2:0] C1_JAL_ADDIW  = 3'b001;
    localparam logic [2:0] C1_LI         = 3'b010;
    localparam logic [2:0] C1_LUI_SP     = 3'b011;
    localparam logic [2:0] C1_MISC_ALU   = 3'b100;
    localparam logic [2:0] C1_J          = 3'b101;
    localparam logic [2:0] C1_BEQZ       = 3'b110;
    localparam logic [2:0] C1_BNEZ       = 3'b111;

    localparam logic [2:0] C2_SLLI       = 3'b000;
    localparam logic [2:0] C2_FLDSP      = 3'b001;
    localparam logic [2:0] C2_LWSP       = 3'b010;
    localparam logic [2:0] C2_FLWSP_LDSP = 3'b011;
    localparam logic [2:0] C2_JR_MV_ADD  = 3'b100;
    localparam logic [2:0] C2_FSDSP      = 3'b101;
    localparam logic [2:0] C2_SWSP       = 3'b110;
    localparam logic [2:0] C2_FSWSP_SDSP = 3'b111;

    typedef enum logic [3:0] {
        FMT_CR, FMT_CI, FMT_CSS, FMT_CIW, FMT_CL, FMT_CS, FMT_CA, FMT_CB, FMT_CJ
    } rvc_fmt_e;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:1] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:1] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/rvc_expand.sv
// Combinational RVC expander: 16-bit compressed encoding to its 32-bit equivalent.
// Illegal encodings come out as {16'h0, instr_i} with illegal_o set.
module rvc_expand
    import rvc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [15:0] instr_i,
    output logic [31:0] instr_o,
    output logic        illegal_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [15:0] h;
    logic [4:0]  rd, rs2, r1p, r2p;
    logic [5:0]  shamt;
    logic [11:0] imm6, off_4spn, off_lw, off_ld, off_lwsp, off_ldsp, off_swsp, off_sdsp, off_16sp;
    logic [19:0] imm_lui;
    logic [20:1] off_j;
    logic [12:1] off_b;
    logic [31:0] inst;
    logic        ill;

    // Operand fields and immediate scrambles of every RVC format
    always_comb begin
        h        = instr_i;
        rd       = h[11:7];
        rs2      = h[6:2];
        r1p      = {2'b01, h[9:7]};
        r2p      = {2'b01, h[4:2]};
        shamt    = {h[12], h[6:2]};
        imm6     = {{6{h[12]}}, h[12], h[6:2]};
        off_4spn = {2'b00, h[10:7], h[12:11], h[5], h[6], 2'b00};
        off_lw   = {5'b0, h[5], h[12:10], h[6], 2'b00};
        off_ld   = {4'b0, h[6:5], h[12:10], 3'b000};
        off_lwsp = {4'b0, h[3:2], h[12], h[6:4], 2'b00};
        off_ldsp = {3'b0, h[4:2], h[12], h[6:5], 3'b000};
        off_swsp = {4'b0, h[8:7], h[12:9], 2'b00};
        off_sdsp = {3'b0, h[9:7], h[12:10], 3'b000};
        off_16sp = {{3{h[12]}}, h[4:3], h[5], h[2], h[6], 4'b0000};
        imm_lui  = {{14{h[12]}}, h[12], h[6:2]};
        off_j    = {{9{h[12]}}, h[12], h[8], h[10:9], h[6], h[7], h[2], h[11], h[5:3]};
        off_b    = {{4{h[12]}}, h[12], h[6:5], h[2], h[11:10], h[4:3]};
    end

    always_comb begin
        inst = INST_NOP;
        ill  = 1'b0;
        case (h[1:0])
            Q0: begin
                case (h[15:13])
                    C0_ADDI4SPN: begin
                        inst = enc_i(off_4spn, 5'd2, F3_ADD, r2p, OPC_OP_IMM);
                        ill  = (h[12:5] == 8'h00);
                    end
                    C0_FLD:    inst = enc_i(off_ld, r1p, F3_D, r2p, OPC_LOAD_FP);
                    C0_LW:     inst = enc_i(off_lw, r1p, F3_W, r2p, OPC_LOAD);
                    C0_FLW_LD: inst = RV64 ? enc_i(off_ld, r1p, F3_D, r2p, OPC_LOAD)
                                           : enc_i(off_lw, r1p, F3_W, r2p, OPC_LOAD_FP);
                    C0_FSD:    inst = enc_s(off_ld, r2p, r1p, F3_D, OPC_STORE_FP);
                    C0_SW:     inst = enc_s(off_lw, r2p, r1p, F3_W, OPC_STORE);
                    C0_FSW_SD: inst = RV64 ? enc_s(off_ld, r2p, r1p, F3_D, OPC_STORE)
                                           : enc_s(off_lw, r2p, r1p, F3_W, OPC_STORE_FP);
                    default:   ill  = 1'b1;
                endcase
            end
            Q1: begin
                case (h[15:13])
                    C1_ADDI: inst = enc_i(imm6, rd, F3_ADD, rd, OPC_OP_IMM);
                    C1_JAL_ADDIW: begin
                        if (RV64) begin
                            inst = enc_i(imm6, rd, F3_ADD, rd, OPC_OP_IMM_32);
                            ill  = (rd == 5'd0);
                        end else begin
                            inst = enc_j(off_j, 5'd1);
                        end
                    end
                    C1_LI: inst = enc_i(imm6, 5'd0, F3_ADD, rd, OPC_OP_IMM);
                    C1_LUI_SP: begin
                        if (rd == 5'd2) inst = enc_i(off_16sp, 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
                        else            inst = enc_u(imm_lui, rd, OPC_LUI);
                        ill = (shamt == 6'd0);
                    end
                    C1_MISC_ALU: begin
                        case (h[11:10])
                            2'b00: begin
                                inst = enc_i({6'b000000, shamt}, r1p, F3_SR, r1p, OPC_OP_IMM);
                                ill  = !RV64 && h[12];
                            end
                            2'b01: begin
                                inst = enc_i({6'b010000, shamt}, r1p, F3_SR, r1p, OPC_OP_IMM);
                                ill  = !RV64 && h[12];
                            end
                            2'b10: inst = enc_i(imm6, r1p, F3_AND, r1p, OPC_OP_IMM);
                            default: begin
                                case ({h[12], h[6:5]})
                                    3'b000: inst = enc_r(F7_SUB,  r2p, r1p, F3_ADD, r1p, OPC_OP);
                                    3'b001: inst = enc_r(F7_ZERO, r2p, r1p, F3_XOR, r1p, OPC_OP);
                                    3'b010: inst = enc_r(F7_ZERO, r2p, r1p, F3_OR,  r1p, OPC_OP);
                                    3'b011: inst = enc_r(F7_ZERO, r2p, r1p, F3_AND, r1p, OPC_OP);
                                    3'b100: begin
                                        inst = enc_r(F7_SUB, r2p, r1p, F3_ADD, r1p, OPC_OP_32);
                                        ill  = !RV64;
                                    end
                                    3'b101: begin
                                        inst = enc_r(F7_ZERO, r2p, r1p, F3_ADD, r1p, OPC_OP_32);
                                        ill  = !RV64;
                                    end
                                    default: ill = 1'b1;
                                endcase
                            end
                        endcase
                    end
                    C1_J:    inst = enc_j(off_j, 5'd0);
                    C1_BEQZ: inst = enc_b(off_b, 5'd0, r1p, F3_BEQ);
                    default: inst = enc_b(off_b, 5'd0, r1p, F3_BNE);
                endcase
            end
            Q2: begin
                case (h[15:13])
                    C2_SLLI: begin
                        inst = enc_i({6'b000000, shamt}, rd, F3_SLL, rd, OPC_OP_IMM);
                        ill  = !RV64 && h[12];
                    end
                    C2_FLDSP: inst = enc_i(off_ldsp, 5'd2, F3_D, rd, OPC_LOAD_FP);
                    C2_LWSP: begin
                        inst = enc_i(off_lwsp, 5'd2, F3_W, rd, OPC_LOAD);
                        ill  = (rd == 5'd0);
                    end
                    C2_FLWSP_LDSP: begin
                        if (RV64) begin
                            inst = enc_i(off_ldsp, 5'd2, F3_D, rd, OPC_LOAD);
                            ill  = (rd == 5'd0);
                        end else begin
                            inst = enc_i(off_lwsp, 5'd2, F3_W, rd, OPC_LOAD_FP);
                        end
                    end
                    C2_JR_MV_ADD: begin
                        if (!h[12]) begin
                            if (rs2 == 5'd0) begin
                                inst = enc_i(12'd0, rd, F3_ADD, 5'd0, OPC_JALR);
                                ill  = (rd == 5'd0);
                            end else begin
                                inst = enc_r(F7_ZERO, rs2, 5'd0, F3_ADD, rd, OPC_OP);
                            end
                        end else if (rs2 == 5'd0) begin
                            inst = (rd == 5'd0) ? INST_EBREAK
                                                : enc_i(12'd0, rd, F3_ADD, 5'd1, OPC_JALR);
                        end else begin
                            inst = enc_r(F7_ZERO, rs2, rd, F3_ADD, rd, OPC_OP);
                        end
                    end
                    C2_FSDSP: inst = enc_s(off_sdsp, rs2, 5'd2, F3_D, OPC_STORE_FP);
                    C2_SWSP:  inst = enc_s(off_swsp, rs2, 5'd2, F3_W, OPC_STORE);
                    default:  inst = RV64 ? enc_s(off_sdsp, rs2, 5'd2, F3_D, OPC_STORE)
                                          : enc_s(off_swsp, rs2, 5'd2, F3_W, OPC_STORE_FP);
                endcase
            end
            // Quadrant 3 is not a compressed encoding
            default: ill = 1'b1;
        endcase
    end

    assign instr_o   = ill ? {16'h0000, instr_i} : inst;
    assign illegal_o = ill;

endmodule

// File: rtl/rvc_align_expand.sv
// Fetch-side halfword aligner: buffers fetch beats, reassembles straddling
// instructions, expands RVC and issues one instruction plus PC per cycle.
module rvc_align_expand
    import rvc_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    FETCH_W  = 32,
    parameter int unsigned    BUF_HW   = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic [XLEN-1:0]    flush_pc,
    input  logic               fetch_valid,
    output logic               fetch_ready,
    input  logic [FETCH_W-1:0] fetch_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_is_rvc,
    output logic               out_illegal
);

    localparam int unsigned NHW = FETCH_W / 16;
    localparam int unsigned PW  = $clog2(BUF_HW);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned SKW = $clog2(NHW);

    logic [15:0]     hw_q [BUF_HW];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d, push_n, pop_n;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [SKW-1:0]  skip_q, skip_d;

    logic [15:0] h0, h1;
    logic        is_rvc, complete, push, pop;
    logic [31:0] exp_inst;
    logic        exp_ill;

    rvc_expand #(.XLEN(XLEN)) u_expand (
        .instr_i   (h0),
        .instr_o   (exp_inst),
        .illegal_o (exp_ill)
    );

    // Head decode and handshakes; fetch_ready depends on registered count only
    always_comb begin
        h0          = hw_q[rd_ptr_q];
        h1          = hw_q[rd_ptr_q + PW'(1)];
        is_rvc      = (h0[1:0] != 2'b11);
        complete    = is_rvc ? (count_q >= CW'(1)) : (count_q >= CW'(2));
        fetch_ready = ((CW'(BUF_HW) - count_q) >= CW'(NHW));
        out_valid   = complete && !flush;
        push        = fetch_valid && fetch_ready && !flush;
        pop         = out_valid && out_ready;
        push_n      = push ? (CW'(NHW) - CW'(skip_q)) : '0;
        pop_n       = pop ? (is_rvc ? CW'(1) : CW'(2)) : '0;
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        head_pc_d = head_pc_q;
        skip_d    = skip_q;
        if (flush) begin
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            head_pc_d = flush_pc;
            skip_d    = flush_pc[SKW:1];
        end else begin
            count_d  = count_q + push_n - pop_n;
            wr_ptr_d = wr_ptr_q + PW'(push_n);
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            if (push) skip_d = '0;
            if (pop)  head_pc_d = head_pc_q + (is_rvc ? XLEN'(2) : XLEN'(4));
        end
    end

    always_comb begin
        out_inst    = out_valid ? (is_rvc ? exp_inst : {h1, h0}) : '0;
        out_pc      = head_pc_q;
        out_is_rvc  = out_valid && is_rvc;
        out_illegal = out_valid && is_rvc && exp_ill;
    end

    // Skipped leading halfwords of a redirect beat are never written
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_HW; i++) hw_q[i] <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_PC;
            skip_q    <= RESET_PC[SKW:1];
        end else begin
            for (int i = 0; i < NHW; i++) begin
                if (push && (PW'(i) >= PW'(skip_q)))
                    hw_q[wr_ptr_q + PW'(i) - PW'(skip_q)] <= fetch_data[16*i +: 16];
            end
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            skip_q    <= skip_d;
        end
    end

endmodule

// File: tb/tb_rvc_align_expand.sv
// Directed self-checking bench for rvc_align_expand (RV32, 32-bit beats, 8-halfword buffer).
module tb_rvc_align_expand;

    logic        clock = 1'b0;
    logic        reset_n, flush, fetch_valid, fetch_ready, out_valid, out_ready;
    logic        out_is_rvc, out_illegal;
    logic [31:0] flush_pc, fetch_data, out_inst, out_pc;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    rvc_align_expand #(
        .XLEN(32), .FETCH_W(32), .BUF_HW(8), .RESET_PC(32'h8000_0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .fetch_data  (fetch_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_is_rvc  (out_is_rvc),
        .out_illegal (out_illegal)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic rvc, input logic ill);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, out_pc, pc);
        chk({tag, "_inst"}, out_inst, inst);
        chk({tag, "_rvc"}, 32'(out_is_rvc), 32'(rvc));
        chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush = 1'b1;
        flush_pc = pc;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; flush_pc = '0;
        fetch_valid = 1'b0; fetch_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(fetch_ready), 32'd1);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_pc", out_pc, 32'h8000_0000);
        chk("rst_rvc", 32'(out_is_rvc), 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);

        // First beat after reset: C.NOP then C.LI a0,1
        reset_n = 1'b1;
        fetch_valid = 1'b1; fetch_data = 32'h4505_0001; out_ready = 1'b1;
        tick();
        fetch_valid = 1'b0;
        chk_out("first0", 32'h8000_0000, 32'h0000_0013, 1'b1, 1'b0);
        tick();
        chk_out("first1", 32'h8000_0002, 32'h0010_0513, 1'b1, 1'b0);
        tick();
        chk("first_drain_valid", 32'(out_valid), 32'd0);
        chk("first_drain_pc", out_pc, 32'h8000_0004);

        // Straddle: 32-bit instruction split across two beats, trailing 0x0000
        do_flush(32'h8000_0100);
        chk("flush100_valid", 32'(out_valid), 32'd0);
        chk("flush100_pc", out_pc, 32'h8000_0100);
        fetch_valid = 1'b1; fetch_data = 32'h0513_4505;
        tick();
        fetch_valid = 1'b0;
        chk_out("strad_c", 32'h8000_0100, 32'h0010_0513, 1'b1, 1'b0);
        tick();
        chk("strad_wait_valid", 32'(out_valid), 32'd0);
        chk("strad_wait_pc", out_pc, 32'h8000_0102);
        tick();
        chk("strad_wait2_valid", 32'(out_valid), 32'd0);
        fetch_valid = 1'b1; fetch_data = 32'h0000_0010;
        tick();
        fetch_valid = 1'b0;
        chk_out("strad_32", 32'h8000_0102, 32'h0010_0513, 1'b0, 1'b0);
        tick();
        chk_out("ill_zero", 32'h8000_0106, 32'h0000_0000, 1'b1, 1'b1);
        tick();
        chk("strad_drain_valid", 32'(out_valid), 32'd0);
        chk("strad_drain_pc", out_pc, 32'h8000_0108);

        // Redirect to an odd halfword: first halfword of the beat is dropped
        do_flush(32'h8000_0206);
        fetch_valid = 1'b1; fetch_data = 32'h4505_0001;
        tick();
        fetch_valid = 1'b0;
        chk_out("skip", 32'h8000_0206, 32'h0010_0513, 1'b1, 1'b0);
        tick();
        chk("skip_single_valid", 32'(out_valid), 32'd0);
        chk("skip_single_pc", out_pc, 32'h8000_0208);

        // Backpressure: fill the buffer, then drain eight NOPs
        do_flush(32'h8000_0300);
        out_ready = 1'b0;
        fetch_data = 32'h0001_0001;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fill_ready%0d", i), 32'(fetch_ready), 32'd1);
            fetch_valid = 1'b1;
            tick();
        end
        fetch_valid = 1'b0;
        chk("full_ready", 32'(fetch_ready), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_out($sformatf("drain%0d", i), 32'h8000_0300 + 32'(2 * i), 32'h0000_0013, 1'b1, 1'b0);
            chk($sformatf("drain_ready%0d", i), 32'(fetch_ready), (i >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        chk("drained_valid", 32'(out_valid), 32'd0);
        chk("drained_ready", 32'(fetch_ready), 32'd1);

        // EBREAK and RV32 C.JAL
        do_flush(32'h8000_0400);
        fetch_valid = 1'b1; fetch_data = 32'h2505_9002;
        tick();
        fetch_valid = 1'b0;
        chk_out("ebreak", 32'h8000_0400, 32'h0010_0073, 1'b1, 1'b0);
        tick();
        chk_out("cjal", 32'h8000_0402, 32'h6200_00EF, 1'b1, 1'b0);
        tick();

        // Flush coinciding with output handshake and fetch beat
        do_flush(32'h8000_0500);
        out_ready = 1'b0;
        fetch_valid = 1'b1; fetch_data = 32'h4505_0001;
        tick();
        fetch_valid = 1'b0;
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        flush = 1'b1; flush_pc = 32'h8000_0600;
        fetch_valid = 1'b1; fetch_data = 32'h0001_0001; out_ready = 1'b1;
        #1;
        chk("flush_cycle_valid", 32'(out_valid), 32'd0);
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        chk("post_flush_pc", out_pc, 32'h8000_0600);
        chk("post_flush_ready", 32'(fetch_ready), 32'd1);
        fetch_valid = 1'b1; fetch_data = 32'h4505_0001;
        tick();
        fetch_valid = 1'b0;
        chk_out("post_flush0", 32'h8000_0600, 32'h0000_0013, 1'b1, 1'b0);
        tick();
        chk_out("post_flush1", 32'h8000_0602, 32'h0010_0513, 1'b1, 1'b0);
        tick();

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        fetch_valid = 1'b1; fetch_data = 32'h0001_0001;
        tick();
        fetch_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_pc", out_pc, 32'h8000_0000);
        chk("async_rst_ready", 32'(fetch_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        fetch_valid = 1'b1; fetch_data = 32'h4505_0001;
        tick();
        fetch_valid = 1'b0;
        chk_out("rerst0", 32'h8000_0000, 32'h0000_0013, 1'b1, 1'b0);
        tick();
        chk_out("rerst1", 32'h8000_0002, 32'h0010_0513, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
